sram_like_arbiter: RTL and testbench
====================================

# sram_like_arbiter

Parametrised N-to-1 arbiter for the core's SRAM-like bus (req / addr_ok / data_ok split handshake), generalising the fixed two-port instruction/data arrangement to NUM_CH masters sharing one slave port. It sits between the pipeline stages (or caches) and the single memory bridge. It grants one request per handshake using round-robin priority. An in-order outstanding-ID FIFO routes each data_ok/rdata response back to the channel that issued it.

## Interface
- NUM_CH, 2: number of master channels (2..8).
- OT_DEPTH, 4: maximum outstanding accepted-but-unanswered requests (power of two, ≥2).
- ADDR_W, 32: address width.
- DATA_W, 32: data width; strobe width is DATA_W/8.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- m_req  in  NUM_CH  per-channel request.
- m_wr  in  NUM_CH  per-channel write flag.
- m_size  in  2*NUM_CH  per-channel size; channel k occupies bits [2k+1:2k].
- m_wstrb  in  NUM_CH*DATA_W/8  per-channel byte strobes, packed the same way.
- m_addr  in  NUM_CH*ADDR_W  per-channel address.
- m_wdata  in  NUM_CH*DATA_W  per-channel write data.
- m_addr_ok  out  NUM_CH  per-channel request accepted.
- m_data_ok  out  NUM_CH  per-channel response returned.
- m_rdata  out  DATA_W  read data, broadcast to all channels; valid where m_data_ok is set.
- s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata  out  1/1/2/DATA_W/8/ADDR_W/DATA_W  slave request, muxed from the granted channel.
- s_addr_ok, s_data_ok  in  1  slave handshakes.
- s_rdata  in  DATA_W  slave read data.
- ot_cnt  out  $clog2(OT_DEPTH)+1  current outstanding count.
- err_unexp_rsp  out  1  sticky flag: s_data_ok arrived while the FIFO was empty.

## Operation
- State: grant-lock register (lock_vld, lock_id), round-robin pointer rr_ptr, ID FIFO (OT_DEPTH entries × $clog2(NUM_CH) bits) with wrapping read/write pointers and a count, and err_unexp_rsp.
- Grant selection:
  - If lock_vld, grant = lock_id.
  - Otherwise grant = first k with m_req[k], searching from rr_ptr upward modulo NUM_CH.
- s_req = m_req[grant] & !fifo_full & !reset. s_* payload is muxed from the grant.
- m_addr_ok[k] = s_addr_ok & s_req & (grant == k).
- Lock behaviour:
  - If s_req and !s_addr_ok, set lock_vld and lock_id = grant. The payload stays sourced from the same master until it is accepted. Masters hold req and payload stable until addr_ok.
  - Lock clears on acceptance (s_req & s_addr_ok).
- Acceptance pushes grant into the FIFO and sets rr_ptr = (grant+1) mod NUM_CH.
- Response routing:
  - On s_data_ok with the FIFO non-empty: pop the head; m_data_ok[head] = 1; all other m_data_ok bits = 0.
  - m_rdata = s_rdata, unregistered.
  - The slave returns responses in request order; this is required of the slave.
- s_data_ok with the FIFO empty: no pop, no m_data_ok, err_unexp_rsp set. It clears only on reset.
- Full FIFO: s_req is forced to 0 and no acceptance occurs, even if a pop happens in the same cycle (conservative, no bypass). An existing lock is held.
- Simultaneous push and pop: the count is unchanged and both pointers advance; a push and a pop of the same entry can never coincide.
- Pointer wrap: read and write pointers wrap from OT_DEPTH-1 to 0.

## Timing
- Request path is combinational from m_req to s_req and from s_addr_ok to m_addr_ok: zero added latency.
- Response path is combinational from s_data_ok to m_data_ok and from s_rdata to m_rdata: zero added latency.
- A request accepted in cycle t may receive its response in cycle t+1 or later; the FIFO entry is visible from t+1.
- Reset state: lock_vld=0, rr_ptr=0, FIFO empty, ot_cnt=0, err_unexp_rsp=0.
- While reset is asserted: s_req=0, m_addr_ok=0, m_data_ok=0.
- Reset mid-operation discards all outstanding IDs. Late slave responses afterwards set err_unexp_rsp; the slave must be reset together with the arbiter.

## Configuration
- ARB_FIXED_PRIO_EN:
  - Defined: grant selection ignores rr_ptr and always picks the lowest-index requesting channel. rr_ptr logic is removed. Locking and the FIFO are unchanged.
  - Undefined (default): round-robin as described in Operation.

## Test plan
- NUM_CH=2, ch0 and ch1 both request continuously, s_addr_ok=1 -> grants alternate 0,1,0,1. With ARB_FIXED_PRIO_EN -> grants 0,0,0,0.
- ch1 requests with s_addr_ok=0 for 3 cycles, and ch0 requests in cycle 2 -> s_addr=ch1 addr for all 3 cycles and the first acceptance goes to ch1 (lock held).
- OT_DEPTH=4, 4 accepted requests and no s_data_ok -> ot_cnt=4 and s_req=0 on the 5th request. One s_data_ok in that same cycle -> still no acceptance; acceptance follows in the next cycle.
- Accept ch0 (addr 0x1000), then ch1 (addr 0x2000), then return s_rdata 0xAAAA, 0xBBBB -> m_data_ok[0] with 0xAAAA first, then m_data_ok[1] with 0xBBBB.
- Push/pop over 10 back-to-back accept+response cycles at OT_DEPTH=4 -> pointers wrap, ot_cnt stays at 1, and each response is routed correctly.
- s_data_ok with the FIFO empty -> no m_data_ok and err_unexp_rsp=1. Then reset high for 1 cycle -> err_unexp_rsp=0 and ot_cnt=0.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// N-to-1 arbiter for the split req/addr_ok/data_ok SRAM-like bus with an in-order ID FIFO for responses.
// Build option: define ARB_FIXED_PRIO_EN for lowest-index-first grant instead of round-robin.
module sram_like_arbiter #(
   parameter int NUM_CH   = 2,
   parameter int OT_DEPTH = 4,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_CH-1:0]             m_req,
   input  logic [NUM_CH-1:0]             m_wr,
   input  logic [2*NUM_CH-1:0]           m_size,
   input  logic [NUM_CH*(DATA_W/8)-1:0]  m_wstrb,
   input  logic [NUM_CH*ADDR_W-1:0]      m_addr,
   input  logic [NUM_CH*DATA_W-1:0]      m_wdata,
   output logic [NUM_CH-1:0]             m_addr_ok,
   output logic [NUM_CH-1:0]             m_data_ok,
   output logic [DATA_W-1:0]             m_rdata,
   output logic                          s_req,
   output logic                          s_wr,
   output logic [1:0]                    s_size,
   output logic [DATA_W/8-1:0]           s_wstrb,
   output logic [ADDR_W-1:0]             s_addr,
   output logic [DATA_W-1:0]             s_wdata,
   input  logic                          s_addr_ok,
   input  logic                          s_data_ok,
   input  logic [DATA_W-1:0]             s_rdata,
   output logic [$clog2(OT_DEPTH):0]     ot_cnt,
   output logic                          err_unexp_rsp
);

   localparam int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PTR_W  = $clog2(OT_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int STRB_W = DATA_W / 8;

   logic              lock_vld_r;
   logic [ID_W-1:0]   lock_id_r;
   logic [ID_W-1:0]   fifo_mem_r [OT_DEPTH];
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              err_r;
`ifndef ARB_FIXED_PRIO_EN
   logic [ID_W-1:0]   rr_ptr_r;
`endif

   logic [ID_W-1:0]   grant_s;
   logic [ID_W-1:0]   head_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic              s_req_s;
   logic              accept_s;
   logic              pop_s;

   // Grant selection: locked channel wins, else the first requester in search order
   always_comb begin
      int          pos_v;
      logic [ID_W-1:0] idx_v;
      grant_s = '0;
      pos_v   = 0;
      idx_v   = '0;
      if (lock_vld_r) begin
         grant_s = lock_id_r;
      end else begin
         // Scan from the far end so the last hit is the nearest requester
         for (int i = NUM_CH - 1; i >= 0; i--) begin
`ifdef ARB_FIXED_PRIO_EN
            pos_v = i;
`else
            pos_v = int'(rr_ptr_r) + i;
            pos_v = (pos_v >= NUM_CH) ? (pos_v - NUM_CH) : pos_v;
`endif
            idx_v   = ID_W'(pos_v);
            grant_s = m_req[idx_v] ? idx_v : grant_s;
         end
      end
   end

   assign fifo_full_s  = (cnt_r == CNT_W'(OT_DEPTH));
   assign fifo_empty_s = (cnt_r == CNT_W'(0));
   assign s_req_s      = m_req[grant_s] & ~fifo_full_s & ~reset;
   assign accept_s     = s_req_s & s_addr_ok;
   assign pop_s        = s_data_ok & ~fifo_empty_s & ~reset;
   assign head_s       = fifo_mem_r[rd_ptr_r];

   // Payload mux and per-channel handshake fan-out
   always_comb begin
      s_wr      = 1'b0;
      s_size    = 2'b00;
      s_wstrb   = '0;
      s_addr    = '0;
      s_wdata   = '0;
      m_addr_ok = '0;
      m_data_ok = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         s_wr         = s_wr    | (m_wr[k] & (grant_s == ID_W'(k)));
         s_size       = s_size  | (m_size[2*k +: 2] & {2{grant_s == ID_W'(k)}});
         s_wstrb      = s_wstrb | (m_wstrb[k*STRB_W +: STRB_W] & {STRB_W{grant_s == ID_W'(k)}});
         s_addr       = s_addr  | (m_addr[k*ADDR_W +: ADDR_W] & {ADDR_W{grant_s == ID_W'(k)}});
         s_wdata      = s_wdata | (m_wdata[k*DATA_W +: DATA_W] & {DATA_W{grant_s == ID_W'(k)}});
         m_addr_ok[k] = accept_s & (grant_s == ID_W'(k));
         m_data_ok[k] = pop_s & (head_s == ID_W'(k));
      end
   end

   assign s_req         = s_req_s;
   assign m_rdata       = s_rdata;
   assign ot_cnt        = cnt_r;
   assign err_unexp_rsp = err_r;

   // Grant lock: hold a stalled request on its master until the slave accepts it
   always_ff @(posedge clk) begin
      if (reset) begin
         lock_vld_r <= 1'b0;
         lock_id_r  <= '0;
      end else if (accept_s) begin
         lock_vld_r <= 1'b0;
      end else if (s_req_s && !s_addr_ok) begin
         lock_vld_r <= 1'b1;
         lock_id_r  <= grant_s;
      end
   end

`ifndef ARB_FIXED_PRIO_EN
   // Round-robin pointer moves just past the most recently accepted channel
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_r <= '0;
      end else if (accept_s) begin
         rr_ptr_r <= (grant_s == ID_W'(NUM_CH - 1)) ? '0 : grant_s + ID_W'(1);
      end
   end
`endif

   // ID FIFO pointers and occupancy; no bypass, so a full FIFO blocks even with a pop pending
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         cnt_r    <= '0;
      end else begin
         if (accept_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({accept_s, pop_s})
            2'b10:   cnt_r <= cnt_r + CNT_W'(1);
            2'b01:   cnt_r <= cnt_r - CNT_W'(1);
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   // ID FIFO storage
   always_ff @(posedge clk) begin
      if (accept_s) begin
         fifo_mem_r[wr_ptr_r] <= grant_s;
      end
   end

   // Sticky flag for a response with no outstanding request
   always_ff @(posedge clk) begin
      if (reset) begin
         err_r <= 1'b0;
      end else if (s_data_ok && fifo_empty_s) begin
         err_r <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue-based reference model.
module tb_sram_like_arbiter;

   localparam int NUM_CH   = 3;
   localparam int OT_DEPTH = 4;
   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 32;
   localparam int STRB_W   = DATA_W / 8;

   logic                       clk;
   logic                       reset;
   logic [NUM_CH-1:0]          m_req;
   logic [NUM_CH-1:0]          m_wr;
   logic [2*NUM_CH-1:0]        m_size;
   logic [NUM_CH*STRB_W-1:0]   m_wstrb;
   logic [NUM_CH*ADDR_W-1:0]   m_addr;
   logic [NUM_CH*DATA_W-1:0]   m_wdata;
   logic [NUM_CH-1:0]          m_addr_ok;
   logic [NUM_CH-1:0]          m_data_ok;
   logic [DATA_W-1:0]          m_rdata;
   logic                       s_req;
   logic                       s_wr;
   logic [1:0]                 s_size;
   logic [STRB_W-1:0]          s_wstrb;
   logic [ADDR_W-1:0]          s_addr;
   logic [DATA_W-1:0]          s_wdata;
   logic                       s_addr_ok;
   logic                       s_data_ok;
   logic [DATA_W-1:0]          s_rdata;
   logic [$clog2(OT_DEPTH):0]  ot_cnt;
   logic                       err_unexp_rsp;

   sram_like_arbiter #(
      .NUM_CH(NUM_CH), .OT_DEPTH(OT_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
   ) dut (
      .clk(clk), .reset(reset),
      .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
      .m_addr(m_addr), .m_wdata(m_wdata),
      .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
      .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
      .s_addr(s_addr), .s_wdata(s_wdata),
      .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
      .ot_cnt(ot_cnt), .err_unexp_rsp(err_unexp_rsp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   int                 mdl_q[$];
   bit                 mdl_lock = 1'b0;
   int                 mdl_lock_id = 0;
   int                 mdl_rr = 0;
   bit                 mdl_err = 1'b0;
   logic [NUM_CH-1:0]  mdl_acc = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, then advance the model to the next edge
   always @(negedge clk) begin
      int g;
      int idx;
      int start;
      logic [NUM_CH-1:0] e_aok;
      logic [NUM_CH-1:0] e_dok;
      bit e_sreq;
      check("ot_cnt", 64'(ot_cnt), 64'(mdl_q.size()));
      check("err_unexp_rsp", 64'(err_unexp_rsp), 64'(mdl_err));
      e_aok = '0;
      e_dok = '0;
      e_sreq = 1'b0;
      g = -1;
      if (!reset) begin
         if (mdl_lock) begin
            g = mdl_lock_id;
         end else begin
`ifdef ARB_FIXED_PRIO_EN
            start = 0;
`else
            start = mdl_rr;
`endif
            for (int i = 0; i < NUM_CH; i++) begin
               idx = (start + i) % NUM_CH;
               if (g < 0 && m_req[idx]) g = idx;
            end
         end
         e_sreq = (g >= 0) && m_req[g] && (mdl_q.size() < OT_DEPTH);
         if (e_sreq && s_addr_ok) e_aok[g] = 1'b1;
         if (s_data_ok && mdl_q.size() > 0) e_dok[mdl_q[0]] = 1'b1;
      end
      check("s_req", 64'(s_req), 64'(e_sreq));
      check("m_addr_ok", 64'(m_addr_ok), 64'(e_aok));
      check("m_data_ok", 64'(m_data_ok), 64'(e_dok));
      if (e_sreq) begin
         check("s_addr", 64'(s_addr), 64'(m_addr[g*ADDR_W +: ADDR_W]));
         check("s_wdata", 64'(s_wdata), 64'(m_wdata[g*DATA_W +: DATA_W]));
         check("s_wr", 64'(s_wr), 64'(m_wr[g]));
         check("s_size", 64'(s_size), 64'(m_size[2*g +: 2]));
         check("s_wstrb", 64'(s_wstrb), 64'(m_wstrb[g*STRB_W +: STRB_W]));
      end
      if (e_dok != '0) check("m_rdata", 64'(m_rdata), 64'(s_rdata));
      mdl_acc = e_aok;
      if (reset) begin
         mdl_q.delete();
         mdl_lock = 1'b0;
         mdl_rr = 0;
         mdl_err = 1'b0;
      end else begin
         if (e_dok != '0) void'(mdl_q.pop_front());
         else if (s_data_ok) mdl_err = 1'b1;
         if (e_aok != '0) begin
            mdl_q.push_back(g);
            mdl_lock = 1'b0;
            mdl_rr = (g + 1) % NUM_CH;
         end else if (e_sreq) begin
            mdl_lock = 1'b1;
            mdl_lock_id = g;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic set_ch(input int k, input logic [ADDR_W-1:0] a);
      m_addr[k*ADDR_W +: ADDR_W]  = a;
      m_wdata[k*DATA_W +: DATA_W] = DATA_W'($urandom());
      m_wr[k]                     = 1'($urandom_range(0, 1));
      m_size[2*k +: 2]            = 2'($urandom_range(0, 2));
      m_wstrb[k*STRB_W +: STRB_W] = STRB_W'($urandom());
   endtask

   task automatic clear_inputs();
      m_req = '0;
      s_addr_ok = 1'b0;
      s_data_ok = 1'b0;
      s_rdata = '0;
   endtask

   task automatic do_reset();
      step();
      reset = 1'b1;
      clear_inputs();
      step();
      reset = 1'b0;
   endtask

   logic [NUM_CH-1:0] prev_aok;
   logic [NUM_CH-1:0] exp_aok;
   logic [NUM_CH-1:0] pend;

   initial begin
      reset = 1'b1;
      clear_inputs();
      m_wr = '0; m_size = '0; m_wstrb = '0; m_addr = '0; m_wdata = '0;
      step();
      step();
      reset = 1'b0;
      settle();
      check("rst_ot_cnt", 64'(ot_cnt), 64'd0);
      check("rst_err", 64'(err_unexp_rsp), 64'd0);

      // Two continuous requesters, back-to-back accept and response
      do_reset();
      prev_aok = '0;
      for (int i = 0; i < 10; i++) begin
         step();
         set_ch(0, 32'h1000 + 32'(i));
         set_ch(1, 32'h2000 + 32'(i));
         m_req = 3'b011;
         s_addr_ok = 1'b1;
         s_data_ok = (i > 0);
         s_rdata = 32'h100 + 32'(i);
         settle();
`ifdef ARB_FIXED_PRIO_EN
         exp_aok = 3'b001;
`else
         exp_aok = (i % 2 == 0) ? 3'b001 : 3'b010;
`endif
         check("alt_aok", 64'(m_addr_ok), 64'(exp_aok));
         if (i > 0) begin
            check("alt_dok", 64'(m_data_ok), 64'(prev_aok));
            check("alt_cnt", 64'(ot_cnt), 64'd1);
         end
         prev_aok = exp_aok;
      end
      step();
      m_req = '0;
      s_data_ok = 1'b1;
      settle();
      check("alt_last_dok", 64'(m_data_ok), 64'(prev_aok));
      step();
      s_data_ok = 1'b0;
      settle();
      check("alt_drained", 64'(ot_cnt), 64'd0);

      // Lock holds a stalled channel 1 against a later channel 0 request
      do_reset();
      step();
      set_ch(1, 32'h2000);
      m_req = 3'b010;
      settle();
      check("lock_addr1", 64'(s_addr), 64'h2000);
      step();
      set_ch(0, 32'h1000);
      m_req = 3'b011;
      settle();
      check("lock_addr2", 64'(s_addr), 64'h2000);
      step();
      s_addr_ok = 1'b1;
      settle();
      check("lock_addr3", 64'(s_addr), 64'h2000);
      check("lock_aok", 64'(m_addr_ok), 64'b010);
      step();
      m_req = 3'b001;
      settle();
      check("lock_next", 64'(s_addr), 64'h1000);
      check("lock_next_aok", 64'(m_addr_ok), 64'b001);

      // Full FIFO blocks acceptance even with a same-cycle pop
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step();
         set_ch(0, 32'h3000 + 32'(i));
         m_req = 3'b001;
         s_addr_ok = 1'b1;
         settle();
         check("full_fill_aok", 64'(m_addr_ok), 64'b001);
      end
      step();
      set_ch(0, 32'h3004);
      s_data_ok = 1'b1;
      s_rdata = 32'h55;
      settle();
      check("full_cnt", 64'(ot_cnt), 64'd4);
      check("full_sreq", 64'(s_req), 64'd0);
      check("full_aok", 64'(m_addr_ok), 64'd0);
      check("full_dok", 64'(m_data_ok), 64'b001);
      step();
      s_data_ok = 1'b0;
      settle();
      check("full_cnt2", 64'(ot_cnt), 64'd3);
      check("full_sreq2", 64'(s_req), 64'd1);
      check("full_aok2", 64'(m_addr_ok), 64'b001);
      step();
      m_req = '0;
      s_data_ok = 1'b1;
      repeat (3) step();
      step();
      s_data_ok = 1'b0;
      settle();
      check("full_drained", 64'(ot_cnt), 64'd0);

      // Responses routed in request order
      do_reset();
      step();
      set_ch(0, 32'h1000);
      m_req = 3'b001;
      s_addr_ok = 1'b1;
      settle();
      check("route_addr0", 64'(s_addr), 64'h1000);
      step();
      set_ch(1, 32'h2000);
      m_req = 3'b010;
      settle();
      check("route_addr1", 64'(s_addr), 64'h2000);
      check("route_aok1", 64'(m_addr_ok), 64'b010);
      step();
      m_req = '0;
      s_data_ok = 1'b1;
      s_rdata = 32'hAAAA;
      settle();
      check("route_dok0", 64'(m_data_ok), 64'b001);
      check("route_rdata0", 64'(m_rdata), 64'hAAAA);
      step();
      s_rdata = 32'hBBBB;
      settle();
      check("route_dok1", 64'(m_data_ok), 64'b010);
      check("route_rdata1", 64'(m_rdata), 64'hBBBB);
      step();
      s_data_ok = 1'b0;

      // Reset discards outstanding IDs; an unexpected response sets the sticky error
      do_reset();
      step();
      set_ch(0, 32'h4000);
      m_req = 3'b001;
      s_addr_ok = 1'b1;
      settle();
      check("err_push", 64'(m_addr_ok), 64'b001);
      step();
      reset = 1'b1;
      s_data_ok = 1'b1;
      settle();
      check("inrst_sreq", 64'(s_req), 64'd0);
      check("inrst_aok", 64'(m_addr_ok), 64'd0);
      check("inrst_dok", 64'(m_data_ok), 64'd0);
      step();
      reset = 1'b0;
      m_req = '0;
      s_addr_ok = 1'b0;
      settle();
      check("postrst_cnt", 64'(ot_cnt), 64'd0);
      check("unexp_dok", 64'(m_data_ok), 64'd0);
      step();
      s_data_ok = 1'b0;
      settle();
      check("unexp_err", 64'(err_unexp_rsp), 64'd1);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      settle();
      check("err_cleared", 64'(err_unexp_rsp), 64'd0);
      check("err_cnt", 64'(ot_cnt), 64'd0);

      // Randomized traffic with a well-behaved in-order slave
      do_reset();
      pend = '0;
      for (int c = 0; c < 3000; c++) begin
         step();
         if (c % 700 == 699) begin
            reset = 1'b1;
            pend = '0;
            clear_inputs();
            continue;
         end
         reset = 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            if (mdl_acc[k]) pend[k] = 1'b0;
            if (!pend[k] && $urandom_range(0, 2) == 0) begin
               pend[k] = 1'b1;
               set_ch(k, ADDR_W'($urandom()));
            end
         end
         m_req = pend;
         s_addr_ok = ($urandom_range(0, 3) != 0);
         s_data_ok = (mdl_q.size() > 0) && ($urandom_range(0, 2) != 0);
         s_rdata = DATA_W'($urandom());
      end
      step();
      clear_inputs();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
